round_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style rounding unit with selectable rounding mode, valid/ready flow control and exception flags. It sits at the tail of the add/sub and mul datapaths. It takes a normalised or subnormal extended mantissa plus exponent and sign, and produces the final packed exponent and fraction. It supersedes the single-mode combinational rounder: it adds directed modes, overflow saturation, inexact/overflow flags and a 2-stage elastic pipeline.

---
 rtl/round_pipe.sv | 168 ++++++++++++++++
 tb/tb_round_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
// round_pipe: 2-stage elastic IEEE-754-style rounder with flags.
// Define ROUND_PIPE_DIRECTED_EN to honour in_rmode; otherwise RNE only.
module round_pipe #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_SIZE-1:0]    in_exp,
  input  logic [MANTIS_SIZE+3:0] in_mantis,
  input  logic [1:0]             in_rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_SIZE-1:0]    out_exp,
  output logic [MANTIS_SIZE-1:0] out_mantis,
  output logic                   out_inexact,
  output logic                   out_overflow
);

  localparam int E = EXP_SIZE;
  localparam int M = MANTIS_SIZE;

  localparam logic [E-1:0] EXP_MAX = {E{1'b1}};
  localparam logic [E-1:0] EXP_TOP = {{(E-1){1'b1}}, 1'b0};
  localparam logic [E-1:0] EXP_ONE = {{(E-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M+1:0] sum;
    logic         inexact;
    logic         ovf;
    logic         to_inf;
  } s1_t;

  logic s1_v;
  logic s2_v;
  logic s1_en;
  logic s2_en;
  s1_t  s1_d;
  s1_t  s1_q;

  assign s2_en    = ~s2_v | out_ready;
  assign s1_en    = ~s1_v | s2_en;
  assign in_ready = s1_en;
  assign out_valid = s2_v;

  logic [1:0] rmode;
`ifdef ROUND_PIPE_DIRECTED_EN
  assign rmode = in_rmode;
`else
  logic unused_rmode;
  assign unused_rmode = ^in_rmode;
  assign rmode = 2'b00;
`endif

  logic g;
  logic rs;
  logic lsb;
  logic ix;
  logic special;
  logic inc;
  logic to_inf;
  logic away;

  assign g       = in_mantis[2];
  assign rs      = |in_mantis[1:0];
  assign lsb     = in_mantis[3];
  assign ix      = g | rs;
  assign special = &in_exp;

  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b0;
    unique case (rmode)
      2'b00: begin
        inc    = g & (rs | lsb);
        to_inf = 1'b1;
      end
      2'b01: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
      2'b10: begin
        inc    = ix & ~in_sign;
        to_inf = ~in_sign;
      end
      2'b11: begin
        inc    = ix & in_sign;
        to_inf = in_sign;
      end
      default: ;
    endcase
  end

  // Truncating modes still flag overflow when the exact value lies past max finite.
  assign away = to_inf ? inc : ix;

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in_sign;
    s1_d.exp     = in_exp;
    s1_d.sum     = {1'b0, in_mantis[M+3:3]}
                 + (M+2)'(inc & ~special);
    s1_d.inexact = ix & ~special;
    s1_d.ovf     = ~special
                 & (in_exp == EXP_TOP)
                 & (&in_mantis[M+3:3])
                 & away;
    s1_d.to_inf  = to_inf;
  end

  logic [E-1:0] nxt_exp;
  logic [M-1:0] nxt_frac;
  logic         nxt_ix;
  logic         nxt_ovf;

  always_comb begin
    nxt_exp  = s1_q.exp;
    nxt_frac = s1_q.sum[M-1:0];
    nxt_ix   = s1_q.inexact;
    nxt_ovf  = 1'b0;
    if (s1_q.ovf) begin
      nxt_ix   = 1'b1;
      nxt_ovf  = 1'b1;
      nxt_exp  = s1_q.to_inf ? EXP_MAX : EXP_TOP;
      nxt_frac = s1_q.to_inf ? '0 : '1;
    end else if (s1_q.sum[M+1]) begin
      nxt_exp  = s1_q.exp + EXP_ONE;
      nxt_frac = '0;
    end else if (s1_q.exp == '0 && s1_q.sum[M]) begin
      nxt_exp  = EXP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s1_q         <= '0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_mantis   <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_sign     <= s1_q.sign;
          out_exp      <= nxt_exp;
          out_mantis   <= nxt_frac;
          out_inexact  <= nxt_ix;
          out_overflow <= nxt_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_pipe.sv
// tb_round_pipe: directed + random scoreboard bench for round_pipe.
// Expectations follow ROUND_PIPE_DIRECTED_EN the same way the build does.
module tb_round_pipe;

  typedef logic [33:0] res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mantis;
  logic [1:0]  in_rmode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mantis;
  logic        out_inexact;
  logic        out_overflow;

  int    n_vec = 0;
  int    n_err = 0;
  res_t  q[$];
  string tq[$];
  string cur_tag = "";
  bit    rand_rdy = 1'b0;

  always #5 clk = ~clk;

  round_pipe #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mantis(in_mantis), .in_rmode(in_rmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp),
    .out_mantis(out_mantis),
    .out_inexact(out_inexact),
    .out_overflow(out_overflow)
  );

  function automatic res_t model(
    input logic s, input logic [7:0] e,
    input logic [22:0] f, input logic [2:0] grs,
    input logic [1:0] rm_in);
    logic [1:0]  rm;
    logic        g, rs, ix, up, to_inf, away;
    logic [30:0] big;
`ifdef ROUND_PIPE_DIRECTED_EN
    rm = rm_in;
`else
    rm = 2'b00;
`endif
    g  = grs[2];
    rs = grs[1] | grs[0];
    ix = g | rs;
    if (e == 8'hFF) return {s, e, f, 2'b00};
    case (rm)
      2'd0:    up = g & (rs | f[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = ix & ~s;
      default: up = ix & s;
    endcase
    to_inf = (rm == 2'd0) || (rm == 2'd2 && !s)
          || (rm == 2'd3 && s);
    away = to_inf ? up : ix;
    big = {e, f} + 31'(away);
    if (big[30:23] == 8'hFF) begin
      if (to_inf) return {s, 8'hFF, 23'h0, 2'b11};
      return {s, 8'hFE, 23'h7FFFFF, 2'b11};
    end
    big = {e, f} + 31'(up);
    return {s, big[30:23], big[22:0], ix, 1'b0};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(output bit acc);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check(tq[0],
              64'({out_sign, out_exp, out_mantis,
                   out_inexact, out_overflow}),
              64'(q[0]));
        if (out_ready) begin
          void'(q.pop_front());
          void'(tq.pop_front());
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      q.push_back(model(in_sign, in_exp, in_mantis[25:3],
                        in_mantis[2:0], in_rmode));
      tq.push_back(cur_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input string tag, input logic s,
                       input logic [7:0] e,
                       input logic [26:0] m,
                       input logic [1:0] rm);
    cur_tag   = tag;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mantis = m;
    in_rmode  = rm;
  endtask

  task automatic send(input string tag, input logic s,
                      input logic [7:0] e,
                      input logic [26:0] m,
                      input logic [1:0] rm);
    bit acc;
    int n;
    n = 0;
    drive(tag, s, e, m, rm);
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      tick(acc);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    bit exp_acc;
    int cyc;
    int i;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mantis = '0;
    in_rmode  = '0;
    out_ready = 1'b1;
    tick(acc);
    tick(acc);
    rst = 1'b0;
    check("reset_outputs",
          64'({out_valid, out_sign, out_exp, out_mantis,
               out_inexact, out_overflow}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    send("carry_rne", 0, 8'h7F, {1'b1, 23'h7FFFFF, 3'b100}, 2'd0);
    check("latency_c1", 64'(out_valid), 64'd0);
    tick(acc);
    check("latency_c2", 64'(out_valid), 64'd1);
    drain();

    send("tie_even_keep", 0, 8'h40, {1'b1, 23'h2, 3'b100}, 2'd0);
    send("tie_even_up", 0, 8'h40, {1'b1, 23'h3, 3'b100}, 2'd0);
    send("ovf_rne", 0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 2'd0);
    send("ovf_rtz", 0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 2'd1);
    send("ovf_rdn_neg", 1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 2'd3);
    send("ovf_rup_neg", 1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b010}, 2'd2);
    send("ovf_rne_no", 0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b011}, 2'd0);
    send("sub_rup", 0, 8'h00, {1'b0, 23'h7FFFFF, 3'b110}, 2'd2);
    send("sub_rtz", 0, 8'h00, {1'b0, 23'h7FFFFF, 3'b110}, 2'd1);
    send("nan_pass", 1, 8'hFF, {1'b1, 23'h400001, 3'b101}, 2'd0);
    send("exact", 1, 8'h83, {1'b1, 23'h123456, 3'b000}, 2'd2);
    drain();

    out_ready = 1'b0;
    cyc = 0;
    i   = 0;
    drive("bp0", 0, 8'h10, {1'b1, 23'h00000F, 3'b110}, 2'd0);
    while (i < 5 && cyc < 60) begin
      if (cyc == 4) out_ready = 1'b1;
      exp_acc = (cyc < 2) || (cyc >= 4);
      tick(acc);
      check($sformatf("bp_accept_c%0d", cyc),
            64'(acc), 64'(exp_acc));
      if (acc) begin
        i++;
        drive($sformatf("bp%0d", i), i[0], 8'(8'h10 + i),
              {1'b1, 23'(i * 23'h1111), i[2:0]},
              i[1:0]);
      end
      cyc++;
    end
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    send("rst_a", 0, 8'h20, {1'b1, 23'h1, 3'b100}, 2'd0);
    send("rst_b", 0, 8'h21, {1'b1, 23'h2, 3'b100}, 2'd0);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    q.delete();
    tq.delete();
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send("post_rst", 1, 8'h55, {1'b1, 23'h7FFFFF, 3'b111}, 2'd3);
    check("post_rst_c1", 64'(out_valid), 64'd0);
    tick(acc);
    check("post_rst_c2", 64'(out_valid), 64'd1);
    drain();
    repeat (3) tick(acc);

    rand_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send($sformatf("rand%0d", k),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           {1'b1, 23'($urandom), 3'($urandom_range(0, 7))},
           2'($urandom_range(0, 3)));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
